// File: rtl/rc6_encrypt_core.sv
// rc6_encrypt_core: iterative RC6-32/20/16 block encryptor.
// One round per cycle; round keys come from an external combinational ROM.
module rc6_encrypt_core #(
  parameter int ROUNDS = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic [4:0]   key_addr,
  input  logic [63:0]  key_q
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_ROUND = 3'd2,
    S_POST  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [4:0] LAST_R = 5'(ROUNDS);
  localparam logic [4:0] POST_A = 5'(ROUNDS + 1);

  state_e state_q, state_d;

  logic [31:0]  a_q, b_q, c_q, d_q;
  logic [31:0]  a_d, b_d, c_d, d_d;
  logic [4:0]   r_q, r_d;
  logic [127:0] out_q, out_d;

  logic [31:0] s_even, s_odd;
  logic [31:0] t_w, u_w;
  logic [31:0] a_rnd, c_rnd;

  function automatic logic [31:0] rotl32(
    input logic [31:0] x,
    input logic [4:0]  s
  );
    logic [63:0] w;
    w = {x, x} << s;
    return w[63:32];
  endfunction

  // x*(2x+1) mod 2^32; 2x+1 is just x shifted with a forced low bit
  function automatic logic [31:0] quad32(
    input logic [31:0] x
  );
    logic [31:0] p;
    p = x * {x[30:0], 1'b1};
    return p;
  endfunction

  assign s_even = key_q[63:32];
  assign s_odd  = key_q[31:0];

  assign t_w   = rotl32(quad32(b_q), 5'd5);
  assign u_w   = rotl32(quad32(d_q), 5'd5);
  assign a_rnd = rotl32(a_q ^ t_w, u_w[4:0]) + s_even;
  assign c_rnd = rotl32(c_q ^ u_w, t_w[4:0]) + s_odd;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) state_d = S_PRE;
      end
      S_PRE: begin
        state_d = S_ROUND;
      end
      S_ROUND: begin
        if (r_q == LAST_R) state_d = S_POST;
      end
      S_POST: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    key_addr  = 5'd0;
    unique case (state_q)
      S_IDLE:  in_ready  = 1'b1;
      S_ROUND: key_addr  = r_q;
      S_POST:  key_addr  = POST_A;
      S_DONE:  out_valid = 1'b1;
      default: ;
    endcase
  end

  assign out_data = out_q;

  // Round step writes (A,B,C,D) <- (B, C', D, A')
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    c_d   = c_q;
    d_d   = d_q;
    r_d   = r_q;
    out_d = out_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d = in_data[127:96];
          b_d = in_data[95:64];
          c_d = in_data[63:32];
          d_d = in_data[31:0];
        end
      end
      S_PRE: begin
        b_d = b_q + s_even;
        d_d = d_q + s_odd;
        r_d = 5'd1;
      end
      S_ROUND: begin
        a_d = b_q;
        b_d = c_rnd;
        c_d = d_q;
        d_d = a_rnd;
        if (r_q != LAST_R) r_d = r_q + 5'd1;
      end
      S_POST: begin
        a_d   = a_q + s_even;
        c_d   = c_q + s_odd;
        out_d = {a_d, b_q, c_d, d_q};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      d_q   <= '0;
      r_q   <= '0;
      out_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      c_q   <= c_d;
      d_q   <= d_d;
      r_q   <= r_d;
      out_q <= out_d;
    end
  end

endmodule

// File: tb/tb_rc6_encrypt_core.sv
// tb_rc6_encrypt_core: scoreboard bench for the RC6 encryptor.
// Expected ciphertexts come from a plain RC6 model driven off the bench ROM.
module tb_rc6_encrypt_core;

  localparam int ROUNDS = 20;
  localparam int LAT    = ROUNDS + 3;
  localparam int PERIOD = ROUNDS + 4;

  typedef struct {
    logic [127:0] data;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [4:0]   key_addr;
  logic [63:0]  key_q;

  logic [63:0] rom [32];
  exp_t        sb_q [$];
  int          cyc   = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic        prev_v = 1'b0;

  rc6_encrypt_core #(.ROUNDS(ROUNDS)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .key_addr (key_addr),
    .key_q    (key_q)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign key_q = rom[key_addr];

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] x, input int s);
    int k;
    k = s & 31;
    if (k == 0) return x;
    return (x << k) | (x >> (32 - k));
  endfunction

  function automatic logic [31:0] skey(input int k);
    logic [63:0] e;
    e = rom[k / 2];
    return (k % 2 == 0) ? e[63:32] : e[31:0];
  endfunction

  // Textbook RC6 encryption using the words currently in the ROM
  function automatic logic [127:0] model(input logic [127:0] pt);
    logic [31:0] a, b, c, d, t, u, tmp;
    a = pt[127:96];
    b = pt[95:64];
    c = pt[63:32];
    d = pt[31:0];
    b = b + skey(0);
    d = d + skey(1);
    for (int i = 1; i <= ROUNDS; i++) begin
      t = rotl(b * (32'd2 * b + 32'd1), 5);
      u = rotl(d * (32'd2 * d + 32'd1), 5);
      a = rotl(a ^ t, int'(u[4:0])) + skey(2 * i);
      c = rotl(c ^ u, int'(t[4:0])) + skey(2 * i + 1);
      tmp = a; a = b; b = c; c = d; d = tmp;
    end
    a = a + skey(2 * ROUNDS + 2);
    c = c + skey(2 * ROUNDS + 3);
    return {a, b, c, d};
  endfunction

  // RC6 key expansion for the all-zero 16-byte user key
  task automatic load_zero_key_rom;
    logic [31:0] s [44];
    logic [31:0] l [4];
    logic [31:0] ka, kb;
    int i, j;
    for (int k = 0; k < 4; k++) l[k] = 32'd0;
    s[0] = 32'hB7E15163;
    for (int k = 1; k < 44; k++) s[k] = s[k-1] + 32'h9E3779B9;
    ka = 0; kb = 0; i = 0; j = 0;
    for (int k = 0; k < 132; k++) begin
      ka = rotl(s[i] + ka + kb, 3);
      s[i] = ka;
      kb = rotl(l[j] + ka + kb, int'(ka + kb) & 31);
      l[j] = kb;
      i = (i + 1) % 44;
      j = (j + 1) % 4;
    end
    for (int k = 0; k < 32; k++)
      rom[k] = (k < 22) ? {s[2*k], s[2*k+1]} : 64'd0;
  endtask

  task automatic rand_rom;
    for (int k = 0; k < 32; k++) rom[k] = {$urandom, $urandom};
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [4:0] exp_addr(input int k);
    if (k <= 1) return 5'd0;
    if (k <= ROUNDS + 1) return 5'(k - 1);
    if (k == ROUNDS + 2) return 5'(ROUNDS + 1);
    return 5'd0;
  endfunction

  // Monitor: latency on rising out_valid, data on each accepted output
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_v <= 1'b0;
    end else begin
      if (out_valid && !prev_v) begin
        if (sb_q.size() == 0)
          chk("spurious_out_valid", 128'(out_valid), 128'd0);
        else
          chk("latency", 128'(cyc - sb_q[0].cyc), 128'(LAT));
      end
      if (out_valid && out_ready && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("ciphertext", out_data, e.data);
      end
      prev_v <= out_valid;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst       = 1'b1;
    in_valid  = 1'($urandom);
    in_data   = rnd128();
    out_ready = 1'($urandom);
    @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_out_data", out_data, 128'd0);
    chk("rst_key_addr", 128'(key_addr), 128'd0);
    tick();
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    sb_q.delete();
  endtask

  task automatic send(input logic [127:0] pt, input logic [127:0] exp,
                      output int hs);
    bit got;
    got = 0;
    hs = -1;
    in_valid = 1'b1;
    in_data  = pt;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      chk("in_ready_timeout", 128'd0, 128'd1);
    end else begin
      hs = cyc;
      sb_q.push_back('{data: exp, cyc: cyc});
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("out_valid_timeout", 128'd0, 128'd1);
  endtask

  task automatic drain;
    for (int k = 0; k < 300; k++) begin
      if (sb_q.size() == 0) break;
      @(negedge clk);
    end
    if (sb_q.size() != 0) begin
      chk("drain_timeout", 128'(sb_q.size()), 128'd0);
      sb_q.delete();
    end
    tick();
  endtask

  initial begin
    logic [127:0] pt, exp;
    int hs, last;
    bit ok;

    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    for (int k = 0; k < 32; k++) rom[k] = 64'd0;
    tick();
    do_reset();

    // Known-answer vector with the zero-key schedule
    load_zero_key_rom();
    send(128'd0, 128'h36a5c38f_78f7b156_4edf29c1_1ea44898, hs);
    drain();

    // Address trace over one block
    rand_rom();
    pt = rnd128();
    send(pt, model(pt), hs);
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      chk($sformatf("key_addr_c%0d", k), 128'(key_addr), 128'(exp_addr(k)));
    end
    drain();

    // Backpressure
    out_ready = 1'b0;
    pt = rnd128();
    exp = model(pt);
    send(pt, exp, hs);
    wait_valid(ok);
    for (int k = 0; k < 10; k++) begin
      chk("bp_out_data", out_data, exp);
      chk("bp_out_valid", 128'(out_valid), 128'd1);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
      @(negedge clk);
    end
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    chk("bp_in_ready_after", 128'(in_ready), 128'd1);
    tick();
    out_ready = 1'b1;
    drain();

    // Busy: new data held on in_valid while encrypting
    pt = rnd128();
    send(pt, model(pt), hs);
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'b1;
      in_data  = rnd128();
      tick();
    end
    in_valid = 1'b0;
    drain();

    // Back-to-back stream
    rand_rom();
    last = 0;
    for (int i = 0; i < 100; i++) begin
      pt = rnd128();
      send(pt, model(pt), hs);
      if (i > 0 && hs >= 0 && last >= 0)
        chk("period", 128'(hs - last), 128'(PERIOD));
      last = hs;
    end
    drain();

    // Reset during round 10
    pt = rnd128();
    send(pt, model(pt), hs);
    repeat (10) tick();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_in_ready", 128'(in_ready), 128'd1);
    chk("mid_rst_out_valid", 128'(out_valid), 128'd0);
    chk("mid_rst_out_data", out_data, 128'd0);
    chk("mid_rst_key_addr", 128'(key_addr), 128'd0);
    sb_q.delete();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      chk("mid_rst_no_valid", 128'(out_valid), 128'd0);
    end
    tick();
    pt = rnd128();
    send(pt, model(pt), hs);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rc6_encrypt_core.md
# rc6_encrypt_core

Iterative RC6-32/20/16 encryption core that consumes the round-key ROM. It accepts one 128-bit plaintext block, then drives the ROM address through 22 consecutive key-pair entries while performing pre-whitening, 20 rounds at one round per cycle, and post-whitening. It returns the 128-bit ciphertext on a valid/ready output. It sits directly downstream of the key ROM, whose combinational read feeds `key_q` in the same cycle `key_addr` is driven.

## Interface
- `ROUNDS`, default 20: number of RC6 rounds. Key entries used are 0..ROUNDS+1, which must fit in 5 bits.
- `clk` input 1: the single clock. All state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: the plaintext on `in_data` is valid.
- `in_ready` output 1: the core can accept a block. High only in IDLE.
- `in_data` input 128: plaintext. A=[127:96], B=[95:64], C=[63:32], D=[31:0].
- `out_valid` output 1: the ciphertext on `out_data` is valid. Held until it is accepted.
- `out_ready` input 1: the downstream side accepts the ciphertext.
- `out_data` output 128: ciphertext, packed the same way as `in_data`.
- `key_addr` output 5: ROM address.
- `key_q` input 64: ROM data for `key_addr`. Entry k gives S[2k] in [63:32] and S[2k+1] in [31:0].

## Operation
- **States:** IDLE, PRE, ROUND, POST, DONE.
- **IDLE**
  - `in_ready`=1 and `key_addr`=0.
  - When `in_valid`=1, latch A,B,C,D from `in_data`, then go to PRE.
- **PRE**
  - `key_addr`=0.
  - B←B+S[0], D←D+S[1].
  - Round counter r←1, then go to ROUND.
- **ROUND** (r = 1..ROUNDS)
  - `key_addr`=r.
  - t=rotl(B·(2B+1), 5) and u=rotl(D·(2D+1), 5).
  - A'=rotl(A⊕t, u[4:0])+S[2r] and C'=rotl(C⊕u, t[4:0])+S[2r+1].
  - Register (A,B,C,D)←(B, C', D, A').
  - If r=ROUNDS, go to POST; otherwise r←r+1.
- **POST**
  - `key_addr`=ROUNDS+1.
  - A←A+S[2·ROUNDS+2], C←C+S[2·ROUNDS+3].
  - Go to DONE.
- **DONE**
  - `out_valid`=1 and `out_data`={A,B,C,D}. `key_addr`=0.
  - When `out_ready`=1, go to IDLE.
- **Arithmetic**
  - All arithmetic is mod 2^32.
  - Multiplies keep the low 32 bits of the 32×32 product.
  - Rotation amounts use bits [4:0] only; a rotate by 0 leaves the word unchanged.
- **Ignored inputs:** `in_valid` is ignored outside IDLE. `out_ready` is ignored outside DONE.
- **Output stability:** `out_data` changes only when entering DONE; otherwise it holds the last ciphertext.
- **Reset** (including mid-operation)
  - Go to IDLE, abort any block in flight, clear A..D and r to 0.
  - `out_data`=0, `out_valid`=0, `in_ready`=1, `key_addr`=0 in the cycle after `rst` is sampled high.
  - No partial result is ever presented.

## Timing
- **Handshake cycles**
  - Input handshake in cycle 0, where `in_valid`&`in_ready` is sampled.
  - PRE in cycle 1.
  - ROUND in cycles 2..ROUNDS+1.
  - POST in cycle ROUNDS+2.
  - `out_valid` rises in cycle ROUNDS+3, which is cycle 23 for the default ROUNDS=20.
- **Address sequence:** `key_addr` is combinational from state and r: 0, 0, 1..20, 21, 0.
  - `key_q` is consumed in the same cycle, with no registered ROM latency.
- **Throughput:** `in_ready` rises in the cycle after the output handshake.
  - The minimum period is ROUNDS+4 cycles per block (24 cycles by default).
- **Backpressure:** with `out_ready`=0, DONE holds indefinitely and `out_valid` and `out_data` stay stable.

## Test plan
- **Reset:** assert `rst` for 2 cycles with random inputs -> `in_ready`=1, `out_valid`=0, `out_data`=0, `key_addr`=0.
- **Known-answer vector:** ROM loaded with the schedule for the all-zero 128-bit key, `in_data`=0 -> in cycle 23, `out_data`=0x36a5c38f_78f7b156_4edf29c1_1ea44898.
- **Address trace:** during a block, monitor `key_addr` -> exactly 0,0,1,2,…,20,21,0. Random ROM contents and random plaintext; result matches the C reference model.
- **Backpressure:** hold `out_ready`=0 for 10 cycles after `out_valid` -> `out_data` is stable and `in_ready`=0 throughout. Pulse `out_ready` -> `in_ready`=1 next cycle.
- **Busy and back-to-back:** hold `in_valid`=1 with new data while busy -> ignored and the first result is unchanged. 100 back-to-back blocks with `out_ready`=1 -> one block every 24 cycles, all matching the model.
- **Mid-operation reset:** assert `rst` at round 10 -> next cycle IDLE and `out_valid` stays 0. A new block then completes correctly in 23 cycles.
